// File: rtl/pc_sequencer_if.sv
// Bus between the program-counter sequencer and its surroundings
// (decode ROM, ALU, control). The master drives requests and ROM/ALU
// results; the slave is the sequencer itself.
interface pc_sequencer_if;
  logic        run;
  logic        halt_req;
  logic [7:0]  rom_addr;
  logic [3:0]  alu_flags;
  logic        flags_we;
  logic        jump;
  logic [7:0]  jump_addr;
  logic [7:0]  pc;
  logic [3:0]  nzvc;
  logic [7:0]  ir;
  logic [1:0]  state;
  logic        busy;
  logic        done;
  logic [15:0] icount;

  modport master (
    output run, halt_req, rom_addr, alu_flags, flags_we, jump, jump_addr,
    input  pc, nzvc, ir, state, busy, done, icount
  );

  modport slave (
    input  run, halt_req, rom_addr, alu_flags, flags_we, jump, jump_addr,
    output pc, nzvc, ir, state, busy, done, icount
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: FETCH / DECODE / EXEC loop, one instruction
// every three clocks. pc and nzvc feed the decode ROM and stay frozen until
// the EXEC exit edge, where pc, nzvc and the retired-instruction count move.
module pc_sequencer (
  input  logic          clock,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_DECODE = 2'd2;
  localparam logic [1:0] ST_EXEC   = 2'd3;

  localparam logic [7:0]  OP_HALT   = 8'hFF;
  localparam logic [15:0] ICOUNT_MAX = 16'hFFFF;

  logic [1:0]  state_q,  state_d;
  logic [7:0]  pc_q,     pc_d;
  logic [7:0]  ir_q,     ir_d;
  logic [3:0]  nzvc_q,   nzvc_d;
  logic [15:0] icount_q, icount_d;
  logic        halt_q,   halt_d;
  logic        done_q,   done_d;
  logic        stop;

  // A halt seen earlier in the instruction, a halt now, or the HALT opcode
  // all end the run after the current instruction retires.
  assign stop = bus.halt_req | halt_q | (ir_q == OP_HALT);

  // Next-state and datapath update selection
  always_comb begin
    // NOTE: every target gets its held value first, so no branch can leave a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    nzvc_d   = nzvc_q;
    icount_d = icount_q;
    halt_d   = halt_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
        if (bus.halt_req) halt_d = 1'b1;
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
        ir_d    = bus.rom_addr;
        if (bus.halt_req) halt_d = 1'b1;
      end
      ST_EXEC: begin
        // jump_addr == pc simply reloads the same value.
        pc_d = bus.jump ? bus.jump_addr : pc_q + 8'd1;
        if (bus.flags_we) nzvc_d = bus.alu_flags;
        if (icount_q != ICOUNT_MAX) icount_d = icount_q + 16'd1;
        if (stop) begin
          state_d = ST_IDLE;
          halt_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any instruction in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= 8'h00;
      ir_q     <= 8'h00;
      nzvc_q   <= 4'h0;
      icount_q <= 16'h0000;
      halt_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      nzvc_q   <= nzvc_d;
      icount_q <= icount_d;
      halt_q   <= halt_d;
      done_q   <= done_d;
    end
  end

  assign bus.pc     = pc_q;
  assign bus.nzvc   = nzvc_q;
  assign bus.ir     = ir_q;
  assign bus.state  = state_q;
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = done_q;
  assign bus.icount = icount_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. An instruction-level reference model
// (pc, flags, ir, retired count) predicts every observed value; directed
// steps cover branch, wrap, halt, saturation and async reset, followed by
// randomized instructions.
module tb_pc_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_pc     = 0;
  int m_nzvc   = 0;
  int m_ir     = 0;
  int m_icount = 0;
  bit idle     = 1'b1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive_junk();
    // Branch/flag/run inputs outside EXEC must have no effect.
    bus.jump      = 1'b1;
    bus.jump_addr = 8'($urandom);
    bus.flags_we  = 1'b1;
    bus.alu_flags = 4'($urandom);
    bus.run       = 1'b1;
  endtask

  task automatic start_run();
    check("idle_state", 16'(bus.state), 16'd0);
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    idle = 1'b0;
  endtask

  // One full instruction, starting at the negedge inside FETCH.
  task automatic do_instr(input logic [7:0] rom, input bit hf, input bit hd, input bit he,
                          input bit jmp, input logic [7:0] ja, input bit fwe,
                          input logic [3:0] fl);
    bit stop;
    check("fetch_state", 16'(bus.state), 16'd1);
    check("fetch_pc",    16'(bus.pc),    16'(m_pc));
    check("fetch_nzvc",  16'(bus.nzvc),  16'(m_nzvc));
    check("fetch_busy",  16'(bus.busy),  16'd1);
    drive_junk();
    bus.halt_req = hf;
    bus.rom_addr = rom;
    tick();
    check("decode_state", 16'(bus.state), 16'd2);
    check("decode_pc",    16'(bus.pc),    16'(m_pc));
    check("decode_nzvc",  16'(bus.nzvc),  16'(m_nzvc));
    check("decode_ir",    16'(bus.ir),    16'(m_ir));
    drive_junk();
    bus.halt_req = hd;
    tick();
    m_ir = int'(rom);
    check("exec_state", 16'(bus.state), 16'd3);
    check("exec_ir",    16'(bus.ir),    16'(m_ir));
    bus.halt_req  = he;
    bus.jump      = jmp;
    bus.jump_addr = ja;
    bus.flags_we  = fwe;
    bus.alu_flags = fl;
    bus.run       = 1'b0;
    tick();
    m_pc     = jmp ? int'(ja) : (m_pc + 1) % 256;
    if (fwe) m_nzvc = int'(fl);
    m_icount = (m_icount < 65535) ? m_icount + 1 : 65535;
    stop     = hf | hd | he | (rom == 8'hFF);
    bus.halt_req = 1'b0;
    bus.jump     = 1'b0;
    bus.flags_we = 1'b0;
    check("post_pc",     16'(bus.pc),     16'(m_pc));
    check("post_nzvc",   16'(bus.nzvc),   16'(m_nzvc));
    check("post_icount", bus.icount,      16'(m_icount));
    check("post_done",   16'(bus.done),   16'(stop));
    check("post_state",  16'(bus.state),  stop ? 16'd0 : 16'd1);
    if (stop) begin
      check("post_busy", 16'(bus.busy), 16'd0);
      tick();
      check("done_once",  16'(bus.done),  16'd0);
      check("stay_idle",  16'(bus.state), 16'd0);
      check("ir_kept",    16'(bus.ir),    16'(m_ir));
      idle = 1'b1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},  16'(bus.state), 16'd0);
    check({tag, "_pc"},     16'(bus.pc),    16'd0);
    check({tag, "_nzvc"},   16'(bus.nzvc),  16'd0);
    check({tag, "_ir"},     16'(bus.ir),    16'd0);
    check({tag, "_icount"}, bus.icount,     16'd0);
    check({tag, "_busy"},   16'(bus.busy),  16'd0);
    check({tag, "_done"},   16'(bus.done),  16'd0);
  endtask

  initial begin
    bus.run = 1'b0; bus.halt_req = 1'b0; bus.rom_addr = 8'h00; bus.alu_flags = 4'h0;
    bus.flags_we = 1'b0; bus.jump = 1'b0; bus.jump_addr = 8'h00;

    // Reset state
    #12;
    check_reset_values("rst");
    @(negedge clock);
    reset = 1'b1;
    tick();
    tick();
    check("idle_after_rst", 16'(bus.state), 16'd0);

    // Straight-line execution
    start_run();
    repeat (3) do_instr(8'h10, 0, 0, 0, 0, 8'h00, 0, 4'h0);

    // Branch with flag write, then plain sequential step
    do_instr(8'h20, 0, 0, 0, 1, 8'h40, 1, 4'hA);
    do_instr(8'h21, 0, 0, 0, 0, 8'h99, 0, 4'h5);
    // Jump to self
    do_instr(8'h22, 0, 0, 0, 1, 8'(m_pc), 0, 4'h0);

    // Wrap 0xFF -> 0x00
    do_instr(8'h23, 0, 0, 0, 1, 8'hFF, 0, 4'h0);
    do_instr(8'h24, 0, 0, 0, 0, 8'h00, 0, 4'h0);

    // Halt requested in DECODE, resume, sticky halt must be cleared
    do_instr(8'h30, 0, 1, 0, 0, 8'h00, 1, 4'h3);
    start_run();
    do_instr(8'h31, 0, 0, 0, 0, 8'h00, 0, 4'h0);
    // HALT opcode
    do_instr(8'hFF, 0, 0, 0, 0, 8'h00, 0, 4'h0);
    start_run();
    // Halt in FETCH and in EXEC
    do_instr(8'h32, 1, 0, 0, 1, 8'h80, 0, 4'h0);
    start_run();
    do_instr(8'h33, 0, 0, 1, 0, 8'h00, 1, 4'hC);

    // Randomized instructions
    for (int i = 0; i < 40; i++) begin
      logic [7:0] rom;
      if (idle) start_run();
      rom = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      do_instr(rom,
               $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 19) == 0,
               $urandom_range(0, 3) == 0, 8'($urandom),
               $urandom_range(0, 1) == 1, 4'($urandom));
    end

    // Saturation of the retired-instruction count
    if (!idle) do_instr(8'h40, 0, 0, 1, 0, 8'h00, 0, 4'h0);
    force dut.icount_q = 16'hFFFE;
    #1;
    release dut.icount_q;
    m_icount = 65534;
    check("sat_preload", bus.icount, 16'hFFFE);
    start_run();
    do_instr(8'h41, 0, 0, 0, 0, 8'h00, 0, 4'h0);
    do_instr(8'h42, 0, 0, 0, 0, 8'h00, 0, 4'h0);
    do_instr(8'h43, 0, 0, 1, 0, 8'h00, 0, 4'h0);
    check("sat_hold", bus.icount, 16'hFFFF);

    // Asynchronous reset in the middle of EXEC
    start_run();
    drive_junk();
    bus.rom_addr = 8'h55;
    tick();
    drive_junk();
    tick();
    check("pre_rst_exec", 16'(bus.state), 16'd3);
    bus.jump = 1'b1; bus.jump_addr = 8'h77; bus.flags_we = 1'b1; bus.alu_flags = 4'hF;
    bus.run = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_reset_values("arst");
    m_pc = 0; m_nzvc = 0; m_ir = 0; m_icount = 0; idle = 1'b1;
    tick();
    check_reset_values("arst_hold");
    bus.jump = 1'b0; bus.flags_we = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    check("idle_after_arst", 16'(bus.state), 16'd0);
    start_run();
    do_instr(8'h60, 0, 0, 1, 0, 8'h00, 0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port run  input  1  start request; sampled only in IDLE.
REQ-004 SHALL have port halt_req  input  1  stop request; honoured at the end of the current instruction.
REQ-005 SHALL have port rom_addr  input  8  decode-ROM output for the presented pc and nzvc.
REQ-006 SHALL have port alu_flags  input  4  new NZVC value from the ALU.
REQ-007 SHALL have port flags_we  input  1  flag write enable, effective in EXEC only.
REQ-008 SHALL have port jump  input  1  branch-taken indication, effective in EXEC only.
REQ-009 SHALL have port jump_addr  input  8  branch target, effective in EXEC only.
REQ-010 SHALL have port pc  output  8  program counter driven to the decode ROM PC input.
REQ-011 SHALL have port nzvc  output  4  flag register driven to the decode ROM NZVC input.
REQ-012 SHALL have port ir  output  8  latched decode-ROM result.
REQ-013 SHALL have port state  output  2  FSM encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse on the return to IDLE.
REQ-016 SHALL have port icount  output  16  count of retired instructions.

Function
REQ-017 SHALL implement a four-state FSM: IDLE -> FETCH on run=1; FETCH -> DECODE unconditionally; DECODE -> EXEC unconditionally; EXEC -> FETCH, or EXEC -> IDLE when a stop condition holds.
REQ-018 SHALL hold pc and nzvc stable from FETCH through DECODE, so that rom_addr settles combinationally by the end of FETCH.
REQ-019 SHALL latch ir <= rom_addr on the DECODE->EXEC edge; ir SHALL be unchanged in all other states.
REQ-020 SHALL update pc on the EXEC exit edge: jump_addr when jump=1, else pc+1 modulo 256 (0xFF wraps to 0x00).
REQ-021 SHALL load nzvc <= alu_flags on the EXEC exit edge when flags_we=1; SHALL ignore flags_we and jump in all other states.
REQ-022 SHALL increment icount on every EXEC exit edge and saturate at 0xFFFF.
REQ-023 SHALL treat either of the following as a stop condition in EXEC: halt_req=1 sampled in EXEC, or a sticky halt_req seen in FETCH/DECODE, or ir==0xFF (HALT opcode).
REQ-024 SHALL still apply the pc, nzvc and icount updates of the stopping instruction before entering IDLE.
REQ-025 SHALL assert done for exactly the single cycle after the EXEC->IDLE edge; done SHALL be low otherwise.
REQ-026 SHALL clear the sticky halt request on entry to IDLE.
REQ-027 SHALL ignore run while busy=1.
REQ-028 SHALL resume from the retained pc, nzvc and icount when run is asserted in IDLE after a halt; pc and nzvc SHALL NOT be cleared by a halt.
REQ-029 SHALL, when jump=1 and jump_addr==pc, load pc unchanged with no special handling.
REQ-030 SHALL produce one instruction per 3 clocks in continuous operation.

Reset
REQ-031 SHALL, while reset=0 and independent of clock, force state=IDLE, pc=0x00, nzvc=0x0, ir=0x00, icount=0x0000, busy=0, done=0 and sticky halt=0.
REQ-032 SHALL, on reset asserted mid-instruction, abandon that instruction with no pc, nzvc or icount update.
REQ-033 SHALL remain in IDLE after reset deasserts until run=1 is sampled.

Verification
REQ-034 Straight-line: reset, run=1 pulse, jump=0, flags_we=0, rom_addr=0x10 -> pc steps 0x00,0x01,0x02 every 3 clocks; ir=0x10; icount increments per EXEC.
REQ-035 Branch and flags: in EXEC apply jump=1, jump_addr=0x40, flags_we=1, alu_flags=0xA -> next FETCH shows pc=0x40 and nzvc=0xA; with jump=0 and flags_we=0 -> pc+1 and nzvc unchanged.
REQ-036 Wrap: preload pc=0xFF via jump -> next sequential pc=0x00.
REQ-037 Halt: halt_req pulsed in DECODE -> instruction completes, IDLE entered, single done pulse; rom_addr=0xFF -> same stop behaviour; a subsequent run resumes at the retained pc.
REQ-038 Async reset: assert reset=0 mid-EXEC, off a clock edge -> all outputs reach reset values immediately; icount not incremented.
REQ-039 Saturation: force icount=0xFFFE and run 3 instructions -> icount holds at 0xFFFF.
